// File: rtl/mem_arbiter_if.sv
// Pipeline- and RAM-side signal bundle for mem_arbiter.
// The arbiter takes the slave view; the pipeline/RAM environment takes the master view.
interface mem_arbiter_if;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic [31:0] ifData;
   logic        ifReady;
   logic        ifStall;
   logic        memReadIn;
   logic        memWriteIn;
   logic [31:0] memAddrIn;
   logic [31:0] memWDataIn;
   logic [31:0] memDataOut;
   logic        memReady;
   logic        memStall;
   logic        haltIn;
   logic        ramEn;
   logic        ramWe;
   logic [31:0] ramAddr;
   logic [31:0] ramWData;
   logic [31:0] ramRData;
   logic        idle;

   modport slave (
      input  ifReq, ifAddr, memReadIn, memWriteIn, memAddrIn, memWDataIn,
             haltIn, ramRData,
      output ifData, ifReady, ifStall, memDataOut, memReady, memStall,
             ramEn, ramWe, ramAddr, ramWData, idle
   );

   modport master (
      output ifReq, ifAddr, memReadIn, memWriteIn, memAddrIn, memWDataIn,
             haltIn, ramRData,
      input  ifData, ifReady, ifStall, memDataOut, memReady, memStall,
             ramEn, ramWe, ramAddr, ramWData, idle
   );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one multi-cycle RAM port,
// alternating grants on ties so fetch cannot be starved by back-to-back data traffic.
module mem_arbiter #(
   parameter int unsigned LATENCY = 2
) (
   input  logic         clockIn,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_lastData;
   logic        r_grantData;
   logic [31:0] r_ifData;
   logic [31:0] r_memData;
   logic        r_ifReady;
   logic        r_memReady;
   logic        r_ramEn;
   logic        r_ramWe;
   logic [31:0] r_ramAddr;
   logic [31:0] r_ramWData;
   logic        r_idle;

   logic w_memReq;
   logic w_ifCand;
   logic w_grantData;

   assign w_memReq    = bus.memReadIn | bus.memWriteIn;
   assign w_ifCand    = bus.ifReq & ~bus.haltIn;
   // On a tie, data wins unless data took the previous grant.
   assign w_grantData = w_memReq & (~w_ifCand | ~r_lastData);

   always_ff @(posedge clockIn or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_lastData  <= 1'b0;
         r_grantData <= 1'b0;
         r_ifData    <= 32'd0;
         r_memData   <= 32'd0;
         r_ifReady   <= 1'b0;
         r_memReady  <= 1'b0;
         r_ramEn     <= 1'b0;
         r_ramWe     <= 1'b0;
         r_ramAddr   <= 32'd0;
         r_ramWData  <= 32'd0;
         r_idle      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_memReq | w_ifCand) begin
                  r_state     <= S_ACCESS;
                  r_cnt       <= CNT_INIT;
                  r_grantData <= w_grantData;
                  r_lastData  <= w_grantData;
                  r_ramEn     <= 1'b1;
                  r_idle      <= 1'b0;
                  if (w_grantData) begin
                     // Read+write together is treated as a store.
                     r_ramWe    <= bus.memWriteIn;
                     r_ramAddr  <= bus.memAddrIn;
                     r_ramWData <= bus.memWDataIn;
                  end else begin
                     r_ramWe    <= 1'b0;
                     r_ramAddr  <= bus.ifAddr;
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_DONE;
                  r_ramEn <= 1'b0;
                  r_ramWe <= 1'b0;
                  if (r_grantData) begin
                     r_memReady <= 1'b1;
                     if (!r_ramWe) r_memData <= bus.ramRData;
                  end else begin
                     r_ifReady <= 1'b1;
                     r_ifData  <= bus.ramRData;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               r_state    <= S_IDLE;
               r_ifReady  <= 1'b0;
               r_memReady <= 1'b0;
               r_idle     <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_idle  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ifData     = r_ifData;
   assign bus.ifReady    = r_ifReady;
   assign bus.memDataOut = r_memData;
   assign bus.memReady   = r_memReady;
   assign bus.ramEn      = r_ramEn;
   assign bus.ramWe      = r_ramWe;
   assign bus.ramAddr    = r_ramAddr;
   assign bus.ramWData   = r_ramWData;
   assign bus.idle       = r_idle;

   // Stalls drop in the DONE cycle so the stage buffers advance at the edge ending it.
   assign bus.ifStall  = bus.ifReq & ~r_ifReady;
   assign bus.memStall = ~reset & w_memReq & ~r_memReady;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (LATENCY 1, 2, 3) exercised in turn,
// a shared queue of expected completions checked by a monitor on every ready pulse.
module tb_mem_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic r1, r2, r3;
   int   total = 0;
   int   bad   = 0;

   mem_arbiter_if b1();
   mem_arbiter_if b2();
   mem_arbiter_if b3();

   mem_arbiter #(.LATENCY(1)) u1 (.clockIn(clk), .reset(r1), .bus(b1.slave));
   mem_arbiter #(.LATENCY(2)) u2 (.clockIn(clk), .reset(r2), .bus(b2.slave));
   mem_arbiter #(.LATENCY(3)) u3 (.clockIn(clk), .reset(r3), .bus(b3.slave));

   // RAM model: fixed contents, plus one writable word at 0x80.
   logic [31:0] wr80 = 32'd0;

   function automatic logic [31:0] rd(input logic [31:0] a, input logic [31:0] w80);
      case (a)
         32'h40:  rd = 32'hDEADBEEF;
         32'h44:  rd = 32'h11110044;
         32'h80:  rd = w80;
         32'h100: rd = 32'hAAAA0001;
         32'h104: rd = 32'hAAAA0002;
         32'h108: rd = 32'hAAAA0003;
         default: rd = 32'h0;
      endcase
   endfunction

   assign b1.ramRData = rd(b1.ramAddr, wr80);
   assign b2.ramRData = rd(b2.ramAddr, wr80);
   assign b3.ramRData = rd(b3.ramAddr, wr80);

   always @(posedge clk)
      if (b2.ramEn && b2.ramWe && b2.ramAddr == 32'h80) wr80 <= b2.ramWData;

   logic [3:1]  ifr_v, mr_v;
   logic [31:0] ifd_v [1:3];
   logic [31:0] md_v  [1:3];
   assign ifr_v = {b3.ifReady, b2.ifReady, b1.ifReady};
   assign mr_v  = {b3.memReady, b2.memReady, b1.memReady};
   assign ifd_v[1] = b1.ifData;     assign ifd_v[2] = b2.ifData;     assign ifd_v[3] = b3.ifData;
   assign md_v[1]  = b1.memDataOut; assign md_v[2]  = b2.memDataOut; assign md_v[3]  = b3.memDataOut;

   typedef struct packed {
      logic [1:0]  dut;
      logic        mem;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   task automatic push(input int d, input logic m, input logic [31:0] v);
      exp_t e;
      e.dut  = 2'(d);
      e.mem  = m;
      e.data = v;
      sbq.push_back(e);
   endtask

   // Monitor: every ready pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 1; d <= 3; d++) begin
         if (ifr_v[d] || mr_v[d]) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: dut %0d ready if=%b mem=%b, want no pulse",
                        d, ifr_v[d], mr_v[d]);
            end else begin
               e = sbq.pop_front();
               chk("sb_dut", 32'(d), 32'(e.dut));
               chkb("sb_kind", mr_v[d], e.mem);
               chk("sb_data", mr_v[d] ? md_v[d] : ifd_v[d], e.data);
            end
         end
      end
   end

   // Wait (bounded) for a ready pulse; n counts rising edges seen, including the request edge.
   task automatic wait_rdy(input int d, input bit want_mem, output int n);
      bit hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         hit = want_mem ? mr_v[d] : ifr_v[d];
      end
      chkb("ready_seen", hit, 1'b1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] en_exp, st_exp, rdy_exp;

      b1.ifReq = 0; b1.ifAddr = 0; b1.memReadIn = 0; b1.memWriteIn = 0;
      b1.memAddrIn = 0; b1.memWDataIn = 0; b1.haltIn = 0;
      b2.ifReq = 0; b2.ifAddr = 0; b2.memReadIn = 0; b2.memWriteIn = 0;
      b2.memAddrIn = 0; b2.memWDataIn = 0; b2.haltIn = 0;
      b3.ifReq = 0; b3.ifAddr = 0; b3.memReadIn = 0; b3.memWriteIn = 0;
      b3.memAddrIn = 0; b3.memWDataIn = 0; b3.haltIn = 0;
      r1 = 1; r2 = 1; r3 = 1;
      b2.memReadIn = 1;
      repeat (2) @(posedge clk);
      #1;
      chkb("rst_idle", b2.idle, 1'b1);
      chkb("rst_ramEn", b2.ramEn, 1'b0);
      chkb("rst_memStall", b2.memStall, 1'b0);
      chkb("rst_memReady", b2.memReady, 1'b0);
      chk("rst_memDataOut", b2.memDataOut, 32'h0);
      chk("rst_ramAddr", b2.ramAddr, 32'h0);
      b2.memReadIn = 0;
      r1 = 0; r2 = 0; r3 = 0;
      @(posedge clk); #1;

      // Load alone, LATENCY=2
      en_exp = 4'b0110; st_exp = 4'b0111; rdy_exp = 4'b1000;
      b2.memAddrIn = 32'h40; b2.memReadIn = 1;
      push(2, 1'b1, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chkb("ld_ramEn", b2.ramEn, en_exp[i]);
         chkb("ld_memStall", b2.memStall, st_exp[i]);
         chkb("ld_memReady", b2.memReady, rdy_exp[i]);
         if (i == 1) begin
            chk("ld_ramAddr", b2.ramAddr, 32'h40);
            chkb("ld_ramWe", b2.ramWe, 1'b0);
         end
      end
      b2.memReadIn = 0;
      @(posedge clk); #1;

      // Tie from reset: data, then fetch (alternation), then the second load
      r2 = 1; #2; r2 = 0;
      b2.ifAddr = 32'h100; b2.ifReq = 1;
      b2.memAddrIn = 32'h44; b2.memReadIn = 1;
      push(2, 1'b1, 32'h11110044);
      push(2, 1'b0, 32'hAAAA0001);
      push(2, 1'b1, 32'hDEADBEEF);
      wait_rdy(2, 1'b1, n);
      chk("tie_lat", 32'(n), 32'd3);
      b2.memAddrIn = 32'h40;
      wait_rdy(2, 1'b0, n);
      b2.ifReq = 0;
      wait_rdy(2, 1'b1, n);
      b2.memReadIn = 0;
      @(posedge clk); #1;

      // Store with read+write both high
      b2.memAddrIn = 32'h80; b2.memWDataIn = 32'h12345678;
      b2.memReadIn = 1; b2.memWriteIn = 1;
      push(2, 1'b1, 32'hDEADBEEF);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chkb("st_ramEn", b2.ramEn, 1'b1);
         chkb("st_ramWe", b2.ramWe, 1'b1);
         chk("st_ramWData", b2.ramWData, 32'h12345678);
         chk("st_ramAddr", b2.ramAddr, 32'h80);
      end
      wait_rdy(2, 1'b1, n);
      b2.memReadIn = 0; b2.memWriteIn = 0;
      @(posedge clk); #1;
      b2.memReadIn = 1;
      push(2, 1'b1, 32'h12345678);
      wait_rdy(2, 1'b1, n);
      chk("ldback_lat", 32'(n), 32'd3);
      b2.memReadIn = 0;
      @(posedge clk); #1;

      // Halt blocks fetch grants, stores still retire
      b2.haltIn = 1; b2.ifAddr = 32'h104; b2.ifReq = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chkb("halt_idle", b2.idle, 1'b1);
         chkb("halt_ramEn", b2.ramEn, 1'b0);
         chkb("halt_ifStall", b2.ifStall, 1'b1);
      end
      @(posedge clk); #1;
      b2.memAddrIn = 32'h84; b2.memWDataIn = 32'hCAFEF00D; b2.memWriteIn = 1;
      push(2, 1'b1, 32'h12345678);
      wait_rdy(2, 1'b1, n);
      chk("halt_st_lat", 32'(n), 32'd3);
      b2.memWriteIn = 0;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkb("halt_idle2", b2.idle, 1'b1);
      end
      @(posedge clk); #1;
      b2.haltIn = 0;
      push(2, 1'b0, 32'hAAAA0002);
      wait_rdy(2, 1'b0, n);
      chk("unhalt_lat", 32'(n), 32'd3);
      b2.ifReq = 0;

      // Reset in the second ACCESS cycle, LATENCY=3
      @(posedge clk); #1;
      b3.memAddrIn = 32'h90; b3.memWDataIn = 32'h55; b3.memWriteIn = 1;
      @(posedge clk); #1;
      chkb("ab_acc1_ramEn", b3.ramEn, 1'b1);
      @(posedge clk); #1;
      chkb("ab_acc2_ramWe", b3.ramWe, 1'b1);
      r3 = 1;
      #1;
      chkb("ab_ramEn", b3.ramEn, 1'b0);
      chkb("ab_ramWe", b3.ramWe, 1'b0);
      chkb("ab_idle", b3.idle, 1'b1);
      chkb("ab_memStall", b3.memStall, 1'b0);
      b3.memWriteIn = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkb("ab_memReady", b3.memReady, 1'b0);
      end
      @(posedge clk); #1;
      r3 = 0;
      @(posedge clk); #1;
      b3.memAddrIn = 32'h40; b3.memReadIn = 1;
      push(3, 1'b1, 32'hDEADBEEF);
      wait_rdy(3, 1'b1, n);
      chk("ab_post_lat", 32'(n), 32'd4);
      b3.memReadIn = 0;

      // Back-to-back fetches, LATENCY=1
      @(posedge clk); #1;
      b1.ifAddr = 32'h100; b1.ifReq = 1;
      push(1, 1'b0, 32'hAAAA0001);
      push(1, 1'b0, 32'hAAAA0002);
      push(1, 1'b0, 32'hAAAA0003);
      for (int i = 0; i < 3; i++) begin
         wait_rdy(1, 1'b0, n);
         chk("b2b_spacing", 32'(n), (i == 0) ? 32'd2 : 32'd3);
         b1.ifAddr = 32'h100 + 32'(4 * (i + 1));
      end
      b1.ifReq = 0;

      repeat (4) @(posedge clk);
      #1;
      chk("sb_leftover", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
